nco_phase_gen: RTL and testbench
================================

Name: nco_phase_gen

Overview:
- DDS phase generator feeding the sine interpolation stage; its x output drives the sine stage's 14-bit phase input.
- Keeps a 32-bit phase accumulator advanced by a frequency tuning word (FTW) and adds a programmable phase offset.
- Truncates the sum to 14 bits: top 12 bits are the table index, low 2 bits the interpolation fraction.
- A linear-sweep (chirp) state machine ramps the FTW by a signed step for a programmed number of cycles.

Parameters:
- ACC_W, 32, accumulator and FTW width.
- PHASE_W, 14, output phase width; must match the sine stage x width.
- STEP_W, 16, sweep step and sweep length width.
- SWEEP_SHIFT, 16, left shift applied to the sign-extended sweep step before it is added to the FTW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  advance accumulator this cycle.
- sync_clr  in  1  clear accumulator, synchronous.
- ftw_in  in  ACC_W  tuning word.
- ftw_load  in  1  load ftw_in into the active FTW.
- pofs_in  in  PHASE_W  phase offset.
- pofs_load  in  1  load pofs_in.
- sweep_step  in  STEP_W  signed two's-complement FTW increment.
- sweep_len  in  STEP_W  number of enabled sweep cycles.
- sweep_start  in  1  start sweep, sampled in IDLE only.
- x  out  PHASE_W  phase to sine stage.
- x_valid  out  1  x updated this cycle.
- sweep_busy  out  1  sweep state machine in SWEEP.
- sweep_done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (async assert, sync release):
  - acc, ftw, pofs, x and the sweep counter all 0.
  - x_valid, sweep_busy and sweep_done all 0.
  - State is IDLE.
- Accumulator, per cycle:
  - If sync_clr: acc <= 0.
  - Else if enable: acc <= acc + ftw (mod 2^ACC_W).
  - sync_clr beats enable.
  - The add always uses the FTW held before this edge; a same-edge ftw_load takes effect from the next cycle.
- Output:
  - x <= acc_next[ACC_W-1 -: PHASE_W] + pofs (mod 2^PHASE_W), registered. Truncation only, no rounding.
  - x_valid <= enable | sync_clr.
  - Latency: an enable at edge N gives the new x at edge N, with x_valid high for that cycle.
  - x holds its value while enable is low.
- pofs_load: pofs updates at the edge; the new offset is used from the next edge's x.
- Sweep state machine states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start (sweep_start is ignored in SWEEP and DONE). The counter loads sweep_len.
  - In SWEEP, on each enable cycle: ftw <= ftw + (sign_extend(sweep_step) << SWEEP_SHIFT) (mod 2^ACC_W), and the counter decrements.
  - In SWEEP, when the counter reaches 0: go to DONE. No FTW change occurs in the cycle the counter is already 0.
  - sweep_len = 0: SWEEP lasts one cycle with no FTW change, then DONE.
  - DONE: sweep_done = 1 for exactly one cycle, then IDLE. The final FTW is retained.
  - sweep_busy = 1 only in SWEEP.
  - ftw_load in any state loads the FTW and forces IDLE (sweep aborted, no done pulse). It has priority over sweep_start on the same edge.
  - enable low in SWEEP freezes both the FTW and the counter.
- Reset mid-sweep returns to IDLE with FTW = 0 and no sweep_done pulse.

Decomposition:
- Shared package nco_pkg holds:
  - ACC_W, PHASE_W, STEP_W and SWEEP_SHIFT defaults.
  - Sweep state typedef {IDLE, SWEEP, DONE}.
  - Phase index/fraction split constants (INDEX_W = 12, FRAC_W = 2), shared with the sine stage.
- One sub-module nco_sweep_ctrl:
  - Contains the state machine, counter and FTW register with ftw_load/sweep_start arbitration.
  - Outputs ftw, sweep_busy and sweep_done.
  - The top level holds the accumulator, offset and output registers.

Test Plan:
- Linear ramp: reset; ftw_load 0x00040000; enable high -> x = 0x0001, 0x0002, 0x0003… one per cycle, with x_valid high.
- Wrap: ftw 0x40000000 -> x = 0x1000, 0x2000, 0x3000, 0x0000, 0x1000; acc wraps with no glitch.
- Offset: ftw 0x00040000, pofs 0x3FFF -> x = 0x0000, 0x0001… (offset wraps modulo 2^14).
- Sweep: ftw 0, sweep_step 0x0004, sweep_len 3, enable high -> ftw steps 0x40000, 0x80000, 0xC0000.
  - sweep_busy high for 4 cycles; sweep_done pulses once; the final ftw stays 0xC0000.
  - Negative step 0xFFFC from 0xC0000 returns ftw to 0.
- Priority: sync_clr with enable -> x = pofs. ftw_load during SWEEP -> IDLE, no sweep_done, new FTW active.
- Reset mid-sweep: assert rst_n low during SWEEP cycle 2 -> all outputs 0 immediately (async); after release, state IDLE.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants and types for the NCO phase generator and the sine stage it feeds.
package nco_pkg;
    localparam int ACC_W       = 32;
    localparam int PHASE_W     = 14;
    localparam int STEP_W      = 16;
    localparam int SWEEP_SHIFT = 16;
    // Phase word split consumed by the sine stage: table index over interpolation fraction.
    localparam int INDEX_W     = 12;
    localparam int FRAC_W      = 2;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_e;
endpackage

// File: rtl/nco_phase_gen_if.sv
// Control and phase-output bundle between a host/driver and the NCO phase generator.
interface nco_phase_gen_if;
    import nco_pkg::*;

    logic               enable;
    logic               sync_clr;
    logic [ACC_W-1:0]   ftw_in;
    logic               ftw_load;
    logic [PHASE_W-1:0] pofs_in;
    logic               pofs_load;
    logic [STEP_W-1:0]  sweep_step;
    logic [STEP_W-1:0]  sweep_len;
    logic               sweep_start;
    logic [PHASE_W-1:0] x;
    logic               x_valid;
    logic               sweep_busy;
    logic               sweep_done;

    modport master (
        output enable, sync_clr, ftw_in, ftw_load, pofs_in, pofs_load,
               sweep_step, sweep_len, sweep_start,
        input  x, x_valid, sweep_busy, sweep_done
    );

    modport slave (
        input  enable, sync_clr, ftw_in, ftw_load, pofs_in, pofs_load,
               sweep_step, sweep_len, sweep_start,
        output x, x_valid, sweep_busy, sweep_done
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Holds the active FTW and the linear-sweep state machine that ramps it.
module nco_sweep_ctrl
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              ftw_load,
    input  logic [ACC_W-1:0]  ftw_in,
    input  logic              sweep_start,
    input  logic [STEP_W-1:0] sweep_step,
    input  logic [STEP_W-1:0] sweep_len,
    output logic [ACC_W-1:0]  ftw,
    output logic              sweep_busy,
    output logic              sweep_done
);
    sweep_state_e      state, state_n;
    logic [STEP_W-1:0] cnt, cnt_n;
    logic [ACC_W-1:0]  ftw_n;
    logic [ACC_W-1:0]  step_ext;

    assign step_ext = {{(ACC_W-STEP_W){sweep_step[STEP_W-1]}}, sweep_step} << SWEEP_SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ftw   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ftw   <= ftw_n;
        end
    end

    // A host FTW load always wins: it aborts any sweep silently.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ftw_n   = ftw;
        if (ftw_load) begin
            ftw_n   = ftw_in;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state_n = SWEEP;
                        cnt_n   = sweep_len;
                    end
                end
                SWEEP: begin
                    if (cnt == '0) begin
                        state_n = DONE;
                    end else if (enable) begin
                        ftw_n = ftw + step_ext;
                        cnt_n = cnt - STEP_W'(1);
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign sweep_busy = (state == SWEEP);
    assign sweep_done = (state == DONE);
endmodule

// File: rtl/nco_phase_gen.sv
// DDS phase generator: 32-bit accumulator plus offset, truncated to the sine stage phase word.
module nco_phase_gen
    import nco_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    nco_phase_gen_if.slave  bus
);
    logic [ACC_W-1:0]   acc, acc_next;
    logic [ACC_W-1:0]   ftw;
    logic [PHASE_W-1:0] pofs;
    logic [PHASE_W-1:0] x_q;
    logic               x_valid_q;

    nco_sweep_ctrl u_sweep (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (bus.enable),
        .ftw_load    (bus.ftw_load),
        .ftw_in      (bus.ftw_in),
        .sweep_start (bus.sweep_start),
        .sweep_step  (bus.sweep_step),
        .sweep_len   (bus.sweep_len),
        .ftw         (ftw),
        .sweep_busy  (bus.sweep_busy),
        .sweep_done  (bus.sweep_done)
    );

    // ftw is a register, so a same-edge ftw_load only affects the following add.
    always_comb begin
        acc_next = acc;
        if (bus.sync_clr)    acc_next = '0;
        else if (bus.enable) acc_next = acc + ftw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pofs      <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
        end else begin
            acc       <= acc_next;
            x_valid_q <= bus.enable | bus.sync_clr;
            if (bus.pofs_load) pofs <= bus.pofs_in;
            if (bus.enable | bus.sync_clr)
                x_q <= acc_next[ACC_W-1 -: PHASE_W] + pofs;
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed vector bench for nco_phase_gen: ramp, wrap, offset, sweep, priority and reset cases.
module tb_nco_phase_gen;
    import nco_pkg::*;

    typedef struct {
        logic               en;
        logic               clr;
        logic               fl;
        logic [ACC_W-1:0]   ftw;
        logic               pl;
        logic [PHASE_W-1:0] pofs;
        logic               ss;
        logic [STEP_W-1:0]  step;
        logic [STEP_W-1:0]  len;
        logic [PHASE_W-1:0] ex;
        logic               ev;
        logic               eb;
        logic               ed;
    } vec_t;

    localparam int NV = 39;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs [NV];

    nco_phase_gen_if bus ();

    nco_phase_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.enable      = v.en;
        bus.sync_clr    = v.clr;
        bus.ftw_load    = v.fl;
        bus.ftw_in      = v.ftw;
        bus.pofs_load   = v.pl;
        bus.pofs_in     = v.pofs;
        bus.sweep_start = v.ss;
        bus.sweep_step  = v.step;
        bus.sweep_len   = v.len;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " x"},     32'(bus.x),          32'(v.ex));
        check({tag, " valid"}, 32'(bus.x_valid),    32'(v.ev));
        check({tag, " busy"},  32'(bus.sweep_busy), 32'(v.eb));
        check({tag, " done"},  32'(bus.sweep_done), 32'(v.ed));
    endtask

    task automatic step_vec(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    //                    en clr fl ftw           pl pofs     ss step      len    ex       ev eb ed
    initial begin
        // linear ramp
        vecs[0]  = '{0,0,1,32'h0004_0000,0,14'h0000,0,16'h0000,16'd0,14'h0000,0,0,0};
        vecs[1]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0001,1,0,0};
        vecs[2]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0002,1,0,0};
        vecs[3]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0003,1,0,0};
        vecs[4]  = '{0,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0003,0,0,0};
        // wrap
        vecs[5]  = '{0,1,1,32'h4000_0000,0,14'h0000,0,16'h0000,16'd0,14'h0000,1,0,0};
        vecs[6]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h1000,1,0,0};
        vecs[7]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h2000,1,0,0};
        vecs[8]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h3000,1,0,0};
        vecs[9]  = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0000,1,0,0};
        vecs[10] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h1000,1,0,0};
        // offset wraps mod 2^14; new offset only from the next edge
        vecs[11] = '{0,1,1,32'h0004_0000,1,14'h3FFF,0,16'h0000,16'd0,14'h0000,1,0,0};
        vecs[12] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0000,1,0,0};
        vecs[13] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0001,1,0,0};
        // sync_clr beats enable -> x = pofs
        vecs[14] = '{1,1,0,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h3FFF,1,0,0};
        vecs[15] = '{0,0,0,32'h0,        1,14'h0000,0,16'h0000,16'd0,14'h3FFF,0,0,0};
        // positive sweep, step 4 len 3 from ftw 0
        vecs[16] = '{0,1,1,32'h0,        0,14'h0000,0,16'h0000,16'd0,14'h0000,1,0,0};
        vecs[17] = '{1,1,0,32'h0,        0,14'h0000,1,16'h0004,16'd3,14'h0000,1,1,0};
        vecs[18] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h0000,1,1,0};
        vecs[19] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h0001,1,1,0};
        vecs[20] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h0003,1,1,0};
        vecs[21] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h0006,1,0,1};
        vecs[22] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h0009,1,0,0};
        vecs[23] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd3,14'h000C,1,0,0};
        // negative sweep back to ftw 0; sweep_start ignored in SWEEP and DONE
        vecs[24] = '{1,0,0,32'h0,        0,14'h0000,1,16'hFFFC,16'd3,14'h000F,1,1,0};
        vecs[25] = '{1,0,0,32'h0,        0,14'h0000,1,16'hFFFC,16'd3,14'h0012,1,1,0};
        vecs[26] = '{1,0,0,32'h0,        0,14'h0000,1,16'hFFFC,16'd3,14'h0014,1,1,0};
        vecs[27] = '{1,0,0,32'h0,        0,14'h0000,0,16'hFFFC,16'd3,14'h0015,1,1,0};
        vecs[28] = '{1,0,0,32'h0,        0,14'h0000,1,16'hFFFC,16'd3,14'h0015,1,0,1};
        vecs[29] = '{1,0,0,32'h0,        0,14'h0000,0,16'hFFFC,16'd3,14'h0015,1,0,0};
        // ftw_load aborts a frozen sweep, no done pulse
        vecs[30] = '{0,0,0,32'h0,        0,14'h0000,1,16'h0004,16'd5,14'h0015,0,1,0};
        vecs[31] = '{0,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd5,14'h0015,0,1,0};
        vecs[32] = '{0,0,1,32'h0004_0000,0,14'h0000,0,16'h0004,16'd5,14'h0015,0,0,0};
        vecs[33] = '{0,1,0,32'h0,        0,14'h0000,0,16'h0004,16'd5,14'h0000,1,0,0};
        vecs[34] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd5,14'h0001,1,0,0};
        vecs[35] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd5,14'h0002,1,0,0};
        // sweep_len 0: one SWEEP cycle, FTW untouched
        vecs[36] = '{1,0,0,32'h0,        0,14'h0000,1,16'h0004,16'd0,14'h0003,1,1,0};
        vecs[37] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd0,14'h0004,1,0,1};
        vecs[38] = '{1,0,0,32'h0,        0,14'h0000,0,16'h0004,16'd0,14'h0005,1,0,0};
    end

    initial begin
        vec_t v;
        v = '{0,0,0,32'h0,0,14'h0,0,16'h0,16'd0,14'h0,0,0,0};
        drive(v);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset", v);

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++)
            step_vec($sformatf("row%0d", i), vecs[i]);

        // reset asserted asynchronously in the second SWEEP cycle
        step_vec("rs0", '{1,1,1,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0000,1,0,0});
        step_vec("rs1", '{1,0,0,32'h0,0,14'h0,1,16'h0004,16'd3,14'h0000,1,1,0});
        step_vec("rs2", '{1,0,0,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0000,1,1,0});
        step_vec("rs3", '{1,0,0,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0001,1,1,0});
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", '{0,0,0,32'h0,0,14'h0,0,16'h0,16'd0,14'h0000,0,0,0});
        @(negedge clk);
        rst_n = 1'b1;
        // FTW is 0 after reset, so an enabled accumulator stays at x=0 with no sweep activity
        step_vec("post0", '{1,0,0,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0000,1,0,0});
        step_vec("post1", '{1,0,0,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0000,1,0,0});
        step_vec("post2", '{1,0,0,32'h0,0,14'h0,0,16'h0004,16'd3,14'h0000,1,0,0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
